decode_pipe: RTL and testbench

- Instruction-decode stage of the RV32IM pipeline, directly downstream of the fetch stage.
- Consumes the fetch stage's registered Instruction, Program_Count and Program_Count_Plus.
- Contains the 32x32 integer register file (with a writeback port), immediate generation and main control decode.
- Registers all results into the ID/EX boundary for the execute stage, with stall and flush control.

---
 rtl/decode_pipe_if.sv | 44 ++++
 rtl/decode_pipe.sv | 70 +++++++
 tb/tb_decode_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch, writeback and ID/EX boundary signals of the decode stage
interface decode_pipe_if #(parameter int DWIDTH = 32);
  logic              Stall;
  logic              Flush;
  logic [31:0]       Instruction;
  logic [31:0]       Program_Count;
  logic [31:0]       Program_Count_Plus;
  logic              WB_En;
  logic [4:0]        WB_Addr;
  logic [DWIDTH-1:0] WB_Data;
  logic [31:0]       ID_Program_Count;
  logic [31:0]       ID_Program_Count_Plus;
  logic [DWIDTH-1:0] Rs1_Data;
  logic [DWIDTH-1:0] Rs2_Data;
  logic [4:0]        Rs1_Addr;
  logic [4:0]        Rs2_Addr;
  logic [4:0]        Rd_Addr;
  logic [31:0]       Imm;
  logic [2:0]        Funct3;
  logic              Funct7_B5;
  logic              Reg_Write;
  logic              Mem_Read;
  logic              Mem_Write;
  logic              Branch;
  logic              Jal;
  logic              Jalr;
  logic              Alu_Src;
  logic              Lui;
  logic              Auipc;
  logic              Is_Mul;
  logic              Illegal;
  modport master (
    output Stall, Flush, Instruction, Program_Count, Program_Count_Plus, WB_En, WB_Addr, WB_Data,
    input  ID_Program_Count, ID_Program_Count_Plus, Rs1_Data, Rs2_Data, Rs1_Addr, Rs2_Addr, Rd_Addr,
           Imm, Funct3, Funct7_B5, Reg_Write, Mem_Read, Mem_Write, Branch, Jal, Jalr, Alu_Src, Lui,
           Auipc, Is_Mul, Illegal
  );
  modport slave (
    input  Stall, Flush, Instruction, Program_Count, Program_Count_Plus, WB_En, WB_Addr, WB_Data,
    output ID_Program_Count, ID_Program_Count_Plus, Rs1_Data, Rs2_Data, Rs1_Addr, Rs2_Addr, Rd_Addr,
           Imm, Funct3, Funct7_B5, Reg_Write, Mem_Read, Mem_Write, Branch, Jal, Jalr, Alu_Src, Lui,
           Auipc, Is_Mul, Illegal
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: RV32IM decode stage with register file, immediate generation and ID/EX register
module decode_pipe #(
  parameter int DWIDTH   = 32,
  parameter int NUM_REGS = 32
) (
  input logic          Clk_Core,
  input logic          Rst_Core_N,
  decode_pipe_if.slave dp
);
  logic [DWIDTH-1:0] rf [NUM_REGS];
  logic [31:0]       ins;
  logic [6:0]        op;
  logic              r_t, i_t, ld_t, st_t, br_t, jal_t, jalr_t, lui_t, aui_t;
  logic              wr, src, ill, mul;
  logic [31:0]       imm;
  logic [4:0]        ra1, ra2;
  logic [DWIDTH-1:0] rd1, rd2;
  logic [125:0]      q, nxt;
  assign ins    = dp.Instruction;
  assign op     = ins[6:0];
  assign r_t    = op == 7'b0110011;
  assign i_t    = op == 7'b0010011;
  assign ld_t   = op == 7'b0000011;
  assign st_t   = op == 7'b0100011;
  assign br_t   = op == 7'b1100011;
  assign jal_t  = op == 7'b1101111;
  assign jalr_t = op == 7'b1100111;
  assign lui_t  = op == 7'b0110111;
  assign aui_t  = op == 7'b0010111;
  assign wr     = r_t | i_t | ld_t | jal_t | jalr_t | lui_t | aui_t;
  assign src    = i_t | ld_t | st_t | jalr_t | lui_t | aui_t;
  assign mul    = r_t && ins[31:25] == 7'b0000001;
  // an all-zero word is the fetch bubble, not an illegal instruction
  assign ill    = ~(wr | st_t | br_t) & (|ins);
  assign imm = (i_t | ld_t | jalr_t) ? {{20{ins[31]}}, ins[31:20]} :
               st_t                  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
               br_t                  ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
               (lui_t | aui_t)       ? {ins[31:12], 12'b0} :
               jal_t                 ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} : '0;
  // while stalled, operands are re-read through the held indices so stall-time writebacks land
  assign ra1 = dp.Stall ? dp.Rs1_Addr : ins[19:15];
  assign ra2 = dp.Stall ? dp.Rs2_Addr : ins[24:20];
  assign rd1 = ra1 == 5'd0 ? '0 : (dp.WB_En && dp.WB_Addr == ra1) ? dp.WB_Data : rf[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : (dp.WB_En && dp.WB_Addr == ra2) ? dp.WB_Data : rf[ra2];
  assign nxt = {dp.Program_Count, dp.Program_Count_Plus, ins[19:15], ins[24:20],
                wr ? ins[11:7] : 5'd0, imm, ins[14:12], ins[30],
                wr, ld_t, st_t, br_t, jal_t, jalr_t, src, lui_t, aui_t, mul, ill};
  assign {dp.ID_Program_Count, dp.ID_Program_Count_Plus, dp.Rs1_Addr, dp.Rs2_Addr, dp.Rd_Addr,
          dp.Imm, dp.Funct3, dp.Funct7_B5, dp.Reg_Write, dp.Mem_Read, dp.Mem_Write, dp.Branch,
          dp.Jal, dp.Jalr, dp.Alu_Src, dp.Lui, dp.Auipc, dp.Is_Mul, dp.Illegal} = q;
  always_ff @(posedge Clk_Core or negedge Rst_Core_N)
    if (!Rst_Core_N)
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    else if (dp.WB_En && dp.WB_Addr != 5'd0)
      rf[dp.WB_Addr] <= dp.WB_Data;
  always_ff @(posedge Clk_Core or negedge Rst_Core_N)
    if (!Rst_Core_N) begin
      q           <= '0;
      dp.Rs1_Data <= '0;
      dp.Rs2_Data <= '0;
    end else if (dp.Flush) begin
      q           <= '0;
      dp.Rs1_Data <= '0;
      dp.Rs2_Data <= '0;
    end else begin
      if (!dp.Stall) q <= nxt;
      dp.Rs1_Data <= rd1;
      dp.Rs2_Data <= rd2;
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed test-plan checks plus random stimulus against a behavioural decode model
module tb_decode_pipe;
  logic Clk_Core = 1'b0;
  logic Rst_Core_N = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  decode_pipe_if dp();
  decode_pipe dut (.Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N), .dp(dp));

  always #5 Clk_Core = ~Clk_Core;

  typedef struct packed {
    logic [31:0] pc, pcp;
    logic [4:0]  r1a, r2a, rda;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic [9:0]  ctl;
    logic        ill;
    logic [31:0] r1d, r2d;
  } exp_t;

  exp_t        exp_q;
  logic [31:0] rf_m [32];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (dp.WB_En && dp.WB_Addr == a) return dp.WB_Data;
    return rf_m[a];
  endfunction

  function automatic exp_t decode(input logic [31:0] i);
    exp_t        e;
    logic [31:0] ii, is, ib, iu, ij;
    logic        wr, mr, mw, br, jl, jr, alu, lu, au, mu;
    e = '0;
    {wr, mr, mw, br, jl, jr, alu, lu, au, mu} = '0;
    ii = 32'($signed(i[31:20]));
    is = 32'($signed({i[31:25], i[11:7]}));
    ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    iu = {i[31:12], 12'h000};
    ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    case (i[6:0])
      7'h33: begin wr = 1; mu = (i[31:25] == 7'd1); end
      7'h13: begin wr = 1; alu = 1; e.imm = ii; end
      7'h03: begin wr = 1; mr = 1; alu = 1; e.imm = ii; end
      7'h23: begin mw = 1; alu = 1; e.imm = is; end
      7'h63: begin br = 1; e.imm = ib; end
      7'h6F: begin jl = 1; wr = 1; e.imm = ij; end
      7'h67: begin jr = 1; wr = 1; alu = 1; e.imm = ii; end
      7'h37: begin lu = 1; wr = 1; alu = 1; e.imm = iu; end
      7'h17: begin au = 1; wr = 1; alu = 1; e.imm = iu; end
      default: e.ill = (i != 32'd0);
    endcase
    e.ctl = {wr, mr, mw, br, jl, jr, alu, lu, au, mu};
    e.pc  = dp.Program_Count;
    e.pcp = dp.Program_Count_Plus;
    e.r1a = i[19:15];
    e.r2a = i[24:20];
    e.rda = wr ? i[11:7] : 5'd0;
    e.f3  = i[14:12];
    e.f7  = i[30];
    e.r1d = rf_read(e.r1a);
    e.r2d = rf_read(e.r2a);
    return e;
  endfunction

  always @(posedge Clk_Core or negedge Rst_Core_N)
    if (!Rst_Core_N) begin
      exp_q = '0;
      for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    end else begin
      if (dp.Flush) exp_q = '0;
      else if (dp.Stall) begin
        exp_q.r1d = rf_read(exp_q.r1a);
        exp_q.r2d = rf_read(exp_q.r2a);
      end else exp_q = decode(dp.Instruction);
      if (dp.WB_En && dp.WB_Addr != 5'd0) rf_m[dp.WB_Addr] = dp.WB_Data;
    end

  always @(negedge Clk_Core)
    if (Rst_Core_N) begin
      cmp("pc", dp.ID_Program_Count, exp_q.pc);
      cmp("pcp", dp.ID_Program_Count_Plus, exp_q.pcp);
      cmp("rs1a", dp.Rs1_Addr, exp_q.r1a);
      cmp("rs2a", dp.Rs2_Addr, exp_q.r2a);
      cmp("rda", dp.Rd_Addr, exp_q.rda);
      cmp("rs1d", dp.Rs1_Data, exp_q.r1d);
      cmp("rs2d", dp.Rs2_Data, exp_q.r2d);
      cmp("imm", dp.Imm, exp_q.imm);
      cmp("f3", dp.Funct3, exp_q.f3);
      cmp("f7b5", dp.Funct7_B5, exp_q.f7);
      cmp("ctl", {dp.Reg_Write, dp.Mem_Read, dp.Mem_Write, dp.Branch, dp.Jal, dp.Jalr,
                  dp.Alu_Src, dp.Lui, dp.Auipc, dp.Is_Mul}, exp_q.ctl);
      cmp("ill", dp.Illegal, exp_q.ill);
    end

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic st, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge Clk_Core);
    dp.Instruction        = ins;
    dp.Program_Count      = pc;
    dp.Program_Count_Plus = pc + 32'd4;
    dp.Stall              = st;
    dp.Flush              = fl;
    dp.WB_En              = we;
    dp.WB_Addr            = wa;
    dp.WB_Data            = wd;
    @(posedge Clk_Core);
    #1;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0]  bad [4] = '{7'h0B, 7'h2F, 7'h7F, 7'h00};
    logic [31:0] r;
    int          k;
    k = $urandom_range(0, 11);
    r = $urandom;
    if (k < 9) r[6:0] = ops[k];
    else if (k == 9) r = 32'd0;
    else r[6:0] = bad[$urandom_range(0, 3)];
    if (r[6:0] == 7'h33) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'h00;
    return r;
  endfunction

  initial begin
    dp.Instruction = 0; dp.Program_Count = 0; dp.Program_Count_Plus = 0;
    dp.Stall = 0; dp.Flush = 0; dp.WB_En = 0; dp.WB_Addr = 0; dp.WB_Data = 0;
    repeat (2) @(posedge Clk_Core);
    #1;
    cmp("rst_imm", dp.Imm, 0);
    cmp("rst_rw", dp.Reg_Write, 0);
    cmp("rst_pc", dp.ID_Program_Count, 0);
    #1 Rst_Core_N = 1'b1;

    step(32'hFFF00093, 32'h0, 0, 0, 0, 0, 0);
    cmp("t1_imm", dp.Imm, 32'hFFFFFFFF);
    cmp("t1_rd", dp.Rd_Addr, 1);
    cmp("t1_rw", dp.Reg_Write, 1);
    cmp("t1_alusrc", dp.Alu_Src, 1);
    cmp("t1_rs1d", dp.Rs1_Data, 0);
    cmp("t1_ill", dp.Illegal, 0);

    step(32'h00528333, 32'h4, 0, 0, 1, 5, 32'h00001234);
    cmp("t2_rs1d", dp.Rs1_Data, 32'h00001234);
    cmp("t2_rs2d", dp.Rs2_Data, 32'h00001234);
    step(32'h00028433, 32'h8, 0, 0, 0, 0, 0);
    cmp("t2_x5", dp.Rs1_Data, 32'h00001234);

    step(32'h00000000, 32'hC, 0, 0, 1, 0, 32'hDEADBEEF);
    step(32'h000003B3, 32'h10, 0, 0, 0, 0, 0);
    cmp("t3_rs1d", dp.Rs1_Data, 0);
    cmp("t3_rs2d", dp.Rs2_Data, 0);

    step(32'hFE000EE3, 32'h100, 0, 0, 0, 0, 0);
    cmp("t4_imm", dp.Imm, 32'hFFFFFFFC);
    cmp("t4_br", dp.Branch, 1);
    cmp("t4_rw", dp.Reg_Write, 0);
    cmp("t4_rd", dp.Rd_Addr, 0);
    cmp("t4_pc", dp.ID_Program_Count, 32'h100);

    step(32'h022081B3, 32'h104, 0, 0, 0, 0, 0);
    cmp("t5_mul", dp.Is_Mul, 1);
    cmp("t5_rw", dp.Reg_Write, 1);
    cmp("t5_rs1a", dp.Rs1_Addr, 1);
    cmp("t5_rs2a", dp.Rs2_Addr, 2);
    cmp("t5_rd", dp.Rd_Addr, 3);
    cmp("t5_f3", dp.Funct3, 0);

    step(32'h00508093, 32'h108, 0, 0, 0, 0, 0);
    cmp("t6_rs1d0", dp.Rs1_Data, 0);
    step(32'h0000007F, 32'h10C, 1, 0, 1, 1, 32'h55);
    cmp("t6_imm_hold", dp.Imm, 5);
    cmp("t6_rw_hold", dp.Reg_Write, 1);
    cmp("t6_pc_hold", dp.ID_Program_Count, 32'h108);
    cmp("t6_rs1d_byp", dp.Rs1_Data, 32'h55);
    step(32'h0000007F, 32'h10C, 1, 0, 0, 0, 0);
    cmp("t6_rs1d_rf", dp.Rs1_Data, 32'h55);
    cmp("t6_ill_hold", dp.Illegal, 0);
    step(32'h0000007F, 32'h10C, 1, 1, 0, 0, 0);
    cmp("t6_fl_imm", dp.Imm, 0);
    cmp("t6_fl_rw", dp.Reg_Write, 0);
    cmp("t6_fl_pc", dp.ID_Program_Count, 0);
    cmp("t6_fl_rs1d", dp.Rs1_Data, 0);
    step(32'h0000007F, 32'h10C, 0, 0, 0, 0, 0);
    cmp("t6_ill", dp.Illegal, 1);
    cmp("t6_ill_rw", dp.Reg_Write, 0);

    step(32'h00028433, 32'h110, 0, 0, 0, 0, 0);
    cmp("ar_pre", dp.Rs1_Data, 32'h00001234);
    #2 Rst_Core_N = 1'b0;
    #1;
    cmp("ar_rs1d", dp.Rs1_Data, 0);
    cmp("ar_pc", dp.ID_Program_Count, 0);
    cmp("ar_rw", dp.Reg_Write, 0);
    @(posedge Clk_Core);
    #2 Rst_Core_N = 1'b1;
    step(32'h00028433, 32'h114, 0, 0, 0, 0, 0);
    cmp("ar_x5_clr", dp.Rs1_Data, 0);

    for (int n = 0; n < 500; n++)
      step(rnd_ins(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
           $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);

    @(negedge Clk_Core);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
